// File: rtl/bcd_updown_counter_pkg.sv
// Shared constants and elaboration-time helpers for the BCD up/down counter.
// Covers the digit width, the largest legal digit value, and decimal-to-BCD conversion.
package bcd_updown_counter_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;
    localparam int MAX_DIGITS = 8;

    // Packs a decimal value into up to eight BCD digits, least significant digit in bits [3:0].
    function automatic logic [DIGIT_W*MAX_DIGITS-1:0] dec_to_bcd(input int unsigned value);
        logic [DIGIT_W*MAX_DIGITS-1:0] r;
        int unsigned v;
        r = '0;
        v = value;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            r[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_updown_counter_digit.sv
// One decimal digit of the counter chain.
// When cin is set, this digit steps up or down by one and raises cout when it rolls over.
module bcd_digit
    import bcd_updown_counter_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit_in,
    input  logic               up_dn,
    input  logic               cin,
    output logic [DIGIT_W-1:0] digit_out,
    output logic               cout
);

    always_comb begin
        digit_out = digit_in;
        cout      = 1'b0;
        if (cin) begin
            if (up_dn) begin
                if (digit_in >= DIGIT_MAX) begin
                    digit_out = '0;
                    cout      = 1'b1;
                end else begin
                    digit_out = digit_in + DIGIT_W'(1);
                end
            end else begin
                if (digit_in == '0) begin
                    digit_out = DIGIT_MAX;
                    cout      = 1'b1;
                end else begin
                    digit_out = digit_in - DIGIT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/bcd_updown_counter.sv
// Multi-digit BCD up/down counter with load, a programmable terminal value, and wrap or saturate behaviour.
// Limit handling and load validation are done here; the digit chain only performs the raw decimal step.
module bcd_updown_counter
    import bcd_updown_counter_pkg::*;
#(
    parameter int NUM_DIGITS = 2,
    parameter int MAX_COUNT  = 99,
    parameter bit SATURATE   = 1'b0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      up_dn,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   load_val,
    output logic [4*NUM_DIGITS-1:0]   count,
    output logic                      tc,
    output logic                      wrap,
    output logic                      load_err
);

    localparam int W = DIGIT_W * NUM_DIGITS;
    localparam logic [DIGIT_W*MAX_DIGITS-1:0] MAX_BCD_ALL = dec_to_bcd(MAX_COUNT);
    localparam logic [W-1:0] MAX_BCD = MAX_BCD_ALL[W-1:0];

    logic [NUM_DIGITS:0] carry;
    logic                carry_unused;
    logic [W-1:0]        stepped;
    logic [W-1:0]        count_step;
    logic                nibbles_ok;
    logic                load_ok;

    assign carry[0]     = 1'b1;
    assign carry_unused = carry[NUM_DIGITS];

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .digit_in  (count[g*DIGIT_W +: DIGIT_W]),
            .up_dn     (up_dn),
            .cin       (carry[g]),
            .digit_out (stepped[g*DIGIT_W +: DIGIT_W]),
            .cout      (carry[g+1])
        );
    end

    assign tc = up_dn ? (count == MAX_BCD) : (count == '0);

    // At a limit the raw decimal step is overridden; elsewhere it cannot leave 0..MAX_COUNT.
    always_comb begin
        count_step = stepped;
        if (tc) begin
            if (SATURATE)
                count_step = count;
            else
                count_step = up_dn ? '0 : MAX_BCD;
        end
    end

    always_comb begin
        nibbles_ok = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (load_val[i*DIGIT_W +: DIGIT_W] > DIGIT_MAX)
                nibbles_ok = 1'b0;
        end
    end

    // With all nibbles valid, BCD ordering matches decimal ordering.
    assign load_ok = nibbles_ok && (load_val <= MAX_BCD);

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else if (load) begin
            if (load_ok)
                count <= load_val;
            load_err <= ~load_ok;
            wrap     <= 1'b0;
        end else if (enable) begin
            count    <= count_step;
            wrap     <= tc;
            load_err <= 1'b0;
        end else begin
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bcd_updown_counter.sv
// Directed and randomised checks of bcd_updown_counter across wrap, saturate and 3-digit configurations.
module tb_bcd_updown_counter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        up_dn;
    logic        load;
    logic [7:0]  lv8;
    logic [11:0] lv12;

    logic [7:0]  cnt0, cnt2;
    logic [11:0] cnt1, cnt3;
    logic        tc0, tc1, tc2, tc3;
    logic        wr0, wr1, wr2, wr3;
    logic        le0, le1, le2, le3;

    int checks   = 0;
    int failures = 0;

    bcd_updown_counter #(.NUM_DIGITS(2), .MAX_COUNT(99), .SATURATE(1'b0)) d0 (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(lv8), .count(cnt0), .tc(tc0), .wrap(wr0), .load_err(le0));
    bcd_updown_counter #(.NUM_DIGITS(3), .MAX_COUNT(250), .SATURATE(1'b0)) d1 (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(lv12), .count(cnt1), .tc(tc1), .wrap(wr1), .load_err(le1));
    bcd_updown_counter #(.NUM_DIGITS(2), .MAX_COUNT(99), .SATURATE(1'b1)) d2 (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(lv8), .count(cnt2), .tc(tc2), .wrap(wr2), .load_err(le2));
    bcd_updown_counter #(.NUM_DIGITS(3), .MAX_COUNT(99), .SATURATE(1'b0)) d3 (
        .clk(clk), .reset(reset), .enable(enable), .up_dn(up_dn), .load(load),
        .load_val(lv12), .count(cnt3), .tc(tc3), .wrap(wr3), .load_err(le3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] bcd(input int v);
        logic [31:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // Decimal reference for the 2-digit, MAX_COUNT=99 instances.
    task automatic model(input bit sat, inout int m, inout logic w, inout logic le);
        bit ok;
        ok = (lv8[7:4] <= 4'd9) && (lv8[3:0] <= 4'd9);
        if (reset) begin
            m = 0; w = 1'b0; le = 1'b0;
        end else if (load) begin
            if (ok) m = int'(lv8[7:4]) * 10 + int'(lv8[3:0]);
            le = !ok;
            w  = 1'b0;
        end else if (enable) begin
            le = 1'b0;
            if (up_dn) begin
                if (m == 99) begin w = 1'b1; if (!sat) m = 0; end
                else begin m++; w = 1'b0; end
            end else begin
                if (m == 0) begin w = 1'b1; if (!sat) m = 99; end
                else begin m--; w = 1'b0; end
            end
        end else begin
            w = 1'b0; le = 1'b0;
        end
    endtask

    int wraps;
    int m0, m2;
    logic w0m, w2m, l0m, l2m;
    logic [31:0] exp_c2 [3];
    logic        exp_w2 [3];

    initial begin
        reset = 1'b1; enable = 1'b1; up_dn = 1'b1; load = 1'b1; lv8 = 8'h55; lv12 = 12'h055;
        step();
        chk("rst_cnt0", cnt0, 8'h00);
        chk("rst_wr0", wr0, 1'b0);
        chk("rst_le0", le0, 1'b0);
        chk("rst_cnt1", cnt1, 12'h000);
        chk("rst_tc_up", tc0, 1'b0);
        up_dn = 1'b0;
        #1;
        chk("rst_tc_dn", tc0, 1'b1);

        // Full up sweep on defaults
        reset = 1'b0; load = 1'b0; enable = 1'b1; up_dn = 1'b1;
        wraps = 0;
        for (int i = 1; i <= 100; i++) begin
            step();
            chk("up_cnt", cnt0, bcd(i % 100));
            chk("up_wrap", wr0, (i == 100));
            wraps += int'(wr0);
            chk("sat_cnt", cnt2, bcd(i < 99 ? i : 99));
        end
        chk("wrap_once", wraps, 1);

        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_cnt", cnt0, 8'h00);
            chk("hold_wr", wr0, 1'b0);
        end

        // 3-digit, MAX 250: decimal borrow and down-wrap
        lv8 = 8'h00; lv12 = 12'h009; load = 1'b1; enable = 1'b0;
        step();
        chk("ld009", cnt1, 12'h009);
        load = 1'b0; enable = 1'b1; up_dn = 1'b0;
        step();
        chk("dn008", cnt1, 12'h008);
        chk("dn008_wr", wr1, 1'b0);
        lv12 = 12'h000; load = 1'b1; enable = 1'b0;
        step();
        chk("ld000", cnt1, 12'h000);
        load = 1'b0; enable = 1'b1; up_dn = 1'b0;
        step();
        chk("dn_wrap_cnt", cnt1, 12'h250);
        chk("dn_wrap_wr", wr1, 1'b1);
        enable = 1'b0;
        step();
        chk("dn_wrap_pulse", wr1, 1'b0);

        // Saturating instance at the top limit
        lv8 = 8'h98; load = 1'b1; enable = 1'b0;
        step();
        chk("sat_ld98", cnt2, 8'h98);
        load = 1'b0; enable = 1'b1; up_dn = 1'b1;
        exp_c2 = '{32'h99, 32'h99, 32'h99};
        exp_w2 = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            step();
            chk("sat_up_cnt", cnt2, exp_c2[i]);
            chk("sat_up_wr", wr2, exp_w2[i]);
            chk("sat_tc", tc2, 1'b1);
        end
        chk("wrap_inst_cnt", cnt0, 8'h01);

        // Load validation
        lv12 = 12'h045; load = 1'b1; enable = 1'b0;
        step();
        chk("ld045", cnt3, 12'h045);
        lv12 = 12'h03A;
        step();
        chk("bad_nib_cnt", cnt3, 12'h045);
        chk("bad_nib_err", le3, 1'b1);
        chk("bad_nib_err1", le1, 1'b1);
        load = 1'b0;
        step();
        chk("err_pulse", le3, 1'b0);
        lv12 = 12'h120; load = 1'b1; enable = 1'b1; up_dn = 1'b1;
        step();
        chk("over_max_cnt", cnt3, 12'h045);
        chk("over_max_err", le3, 1'b1);
        chk("ok_120_cnt", cnt1, 12'h120);
        chk("ok_120_err", le1, 1'b0);
        load = 1'b0; enable = 1'b0;
        step();
        chk("err_pulse2", le3, 1'b0);
        lv12 = 12'h250; load = 1'b1;
        step();
        chk("ld_max_cnt", cnt1, 12'h250);
        chk("ld_max_err", le1, 1'b0);
        lv12 = 12'h251;
        step();
        chk("ld_251_cnt", cnt1, 12'h250);
        chk("ld_251_err", le1, 1'b1);

        // Load beats enable; reset beats load
        lv8 = 8'h99; load = 1'b1; enable = 1'b0;
        step();
        chk("ld99", cnt0, 8'h99);
        lv8 = 8'h42; load = 1'b1; enable = 1'b1; up_dn = 1'b1;
        step();
        chk("ld_en_cnt", cnt0, 8'h42);
        chk("ld_en_wr", wr0, 1'b0);
        reset = 1'b1; load = 1'b1;
        step();
        chk("rst_ld_cnt", cnt0, 8'h00);
        chk("rst_ld_wr", wr0, 1'b0);
        chk("rst_ld_le", le0, 1'b0);
        reset = 1'b0; load = 1'b0; enable = 1'b1; up_dn = 1'b1;
        step();
        chk("resume", cnt0, 8'h01);
        up_dn = 1'b0;
        step();
        chk("dir_chg", cnt0, 8'h00);
        step();
        chk("dn_wrap99", cnt0, 8'h99);
        chk("dn_wrap99_wr", wr0, 1'b1);

        // Random traffic against the decimal model
        reset = 1'b1;
        step();
        reset = 1'b0;
        m0 = 0; m2 = 0; w0m = 1'b0; w2m = 1'b0; l0m = 1'b0; l2m = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            reset  = ($urandom_range(0, 199) == 0);
            enable = ($urandom_range(0, 3) != 0);
            up_dn  = 1'($urandom_range(0, 1));
            load   = ($urandom_range(0, 7) == 0);
            lv8    = 8'($urandom_range(0, 255));
            model(1'b0, m0, w0m, l0m);
            model(1'b1, m2, w2m, l2m);
            step();
            chk("rnd_cnt0", cnt0, bcd(m0));
            chk("rnd_wr0", wr0, w0m);
            chk("rnd_le0", le0, l0m);
            chk("rnd_tc0", tc0, up_dn ? (m0 == 99) : (m0 == 0));
            chk("rnd_nib0", (cnt0[7:4] <= 4'd9) && (cnt0[3:0] <= 4'd9), 1'b1);
            chk("rnd_cnt2", cnt2, bcd(m2));
            chk("rnd_wr2", wr2, w2m);
            chk("rnd_le2", le2, l2m);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_updown_counter.md
BCD_UPDOWN_COUNTER -- requirements
Module: bcd_updown_counter

Interface
REQ-001 Parameter NUM_DIGITS, 2: number of BCD digits; legal range 1..8.
REQ-002 Parameter MAX_COUNT, 99: terminal value in decimal; legal range 1..(10^NUM_DIGITS - 1).
REQ-003 Parameter SATURATE, 0: 0 = wrap at the limits, 1 = hold at the limits.
REQ-004 Port clk, input, 1: rising-edge clock.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port enable, input, 1: count one step on this clock edge.
REQ-007 Port up_dn, input, 1: 1 = increment, 0 = decrement.
REQ-008 Port load, input, 1: load load_val on this clock edge.
REQ-009 Port load_val, input, 4*NUM_DIGITS: BCD value to load; digit 0 in bits [3:0].
REQ-010 Port count, output, 4*NUM_DIGITS: current BCD count, registered.
REQ-011 Port tc, output, 1: terminal count; 1 when (up_dn=1 and count=MAX_COUNT) or (up_dn=0 and count=0); combinational from count and up_dn.
REQ-012 Port wrap, output, 1: registered one-cycle pulse on a limit event.
REQ-013 Port load_err, output, 1: registered one-cycle pulse when a load is rejected.

Function
REQ-014 Priority per edge SHALL be reset > load > enable > hold.
REQ-015 With enable=0 and load=0, count SHALL hold its value.
REQ-016 Increment SHALL be decimal: a digit at 9 becomes 0 and carries into the next digit; no nibble SHALL ever hold A-F.
REQ-017 Decrement SHALL be decimal: a digit at 0 becomes 9 and borrows from the next digit.
REQ-018 Up at MAX_COUNT, SATURATE=0: next count SHALL be 0, and wrap SHALL be 1 on the following cycle.
REQ-019 Down at 0, SATURATE=0: next count SHALL be MAX_COUNT, and wrap SHALL pulse.
REQ-020 SATURATE=1 at a limit: count SHALL hold, and wrap SHALL pulse on every enabled edge spent at the limit.
REQ-021 Count SHALL never exceed MAX_COUNT; the step is exactly one per enabled edge, and there is no transient out-of-range value.
REQ-022 A load SHALL be accepted only if every nibble is 0-9 and the value is at most MAX_COUNT; an accepted load sets count to load_val on the next edge.
REQ-023 A rejected load SHALL leave count unchanged (enable is ignored on that edge) and pulse load_err for one cycle.
REQ-024 Load with enable=1 on the same edge SHALL load only, with no step and no wrap pulse.
REQ-025 Changing up_dn between edges SHALL take effect on the next enabled edge, with latency of one clock.

Reset
REQ-026 On reset=1 at a clock edge: count=0, wrap=0, load_err=0, regardless of load and enable.
REQ-027 Reset asserted mid-count SHALL take effect on that edge; counting resumes from 0 on the first enabled edge after reset deasserts.
REQ-028 There SHALL be no initial-block or power-up dependence; all state is defined by reset.

Structure
REQ-029 A shared package SHALL hold the BCD digit width (4), the digit maximum (9), and a function converting decimal MAX_COUNT to its BCD vector at elaboration time.
REQ-030 The per-digit logic SHALL be sub-module bcd_digit: inputs are digit in, up_dn and carry/borrow in; outputs are next digit and carry/borrow out.
REQ-031 bcd_digit SHALL be instantiated NUM_DIGITS times via generate and chained from digit 0 upward.
REQ-032 Limit comparison and load validation SHALL live in the top module, not in bcd_digit.

Verification
REQ-033 Defaults, reset, then enable=1 and up_dn=1 for 100 edges -> count steps 00,01..99,00; wrap pulses once, on the cycle after 99->00.
REQ-034 NUM_DIGITS=3, MAX_COUNT=250, load 0x009 then one down step -> 0x008; load 0x000 then one down step -> 0x250 with a wrap pulse.
REQ-035 SATURATE=1, defaults, load 0x98, then 3 up steps -> 99,99,99; wrap pulses on the 2nd and 3rd edges; tc=1 while up_dn=1.
REQ-036 Load 0x3A, then load 0x120 with MAX_COUNT=99 (NUM_DIGITS=3) -> count unchanged; load_err pulses once per attempt.
REQ-037 Load=1, enable=1, load_val=0x42 on one edge -> count=42 and no wrap; reset=1 with load=1 on the next edge -> count=00.
REQ-038 Random up_dn/enable/load for 10k cycles against a decimal reference model -> count matches every cycle, with no nibble above 9.
